// File: rtl/boot_image_loader_if.sv
// Byte-stream input and boot RAM port bundle used by boot_image_loader.
interface boot_image_loader_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ram_ce;
  logic              ram_oce;
  logic              ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  // Loader side: consumes the byte stream and drives the boot RAM port.
  modport master (
    input  s_data, s_valid, ram_dout,
    output s_ready, ram_ce, ram_oce, ram_wre, ram_ad, ram_din
  );

  // Environment side: the byte source plus the boot RAM itself.
  modport slave (
    output s_data, s_valid, ram_dout,
    input  s_ready, ram_ce, ram_oce, ram_wre, ram_ad, ram_din
  );
endinterface

// File: rtl/boot_image_loader.sv
// Framed byte-stream boot loader: writes the payload into boot RAM,
// reads it back to verify the checksum, and releases the CPU on success.
module boot_image_loader #(
  parameter int         ADDR_W      = 11,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  boot_image_loader_if.master bus,
  output logic                cpu_hold,
  output logic                done,
  output logic [2:0]          err
);
  // One extra bit so a full 2^ADDR_W image length/count never wraps.
  localparam int          CNT_W   = ADDR_W + 1;
  localparam int          TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA, S_CHK, S_VERIFY, S_DONE, S_ERROR
  } state_t;

  state_t            r_state, w_state;
  logic [2:0]        r_err, w_err;
  logic [7:0]        r_len_hi, w_len_hi;
  logic [CNT_W-1:0]  r_len, w_len;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [7:0]        r_sum, w_sum;
  logic [7:0]        r_rsum, w_rsum;
  logic [7:0]        r_chk, w_chk;
  logic [TMO_W-1:0]  r_tcnt, w_tcnt;
  logic              r_ram_ce, w_ram_ce;
  logic              r_ram_oce, w_ram_oce;
  logic              r_ram_wre, w_ram_wre;
  logic [ADDR_W-1:0] r_ram_ad, w_ram_ad;
  logic [7:0]        r_ram_din, w_ram_din;

  logic              w_s_ready;
  logic              w_accept;
  logic              w_in_frame;
  logic [15:0]       w_len16;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [7:0]        w_vsum;

  assign w_s_ready  = (r_state != S_VERIFY);
  assign w_accept   = bus.s_valid && w_s_ready;
  assign w_in_frame = (r_state == S_LEN_H) || (r_state == S_LEN_L) ||
                      (r_state == S_DATA)  || (r_state == S_CHK);
  assign w_len16    = {r_len_hi, bus.s_data};
  assign w_cnt_inc  = r_cnt + 1'b1;
  // Readback sum including the byte arriving for the last issued address.
  assign w_vsum     = r_rsum + bus.ram_dout + r_chk;

  // Next-state, datapath and RAM-port decode; RAM strobes are single-cycle pulses.
  always_comb begin
    w_state   = r_state;
    w_err     = r_err;
    w_len_hi  = r_len_hi;
    w_len     = r_len;
    w_cnt     = r_cnt;
    w_sum     = r_sum;
    w_rsum    = r_rsum;
    w_chk     = r_chk;
    w_tcnt    = r_tcnt;
    w_ram_ce  = 1'b0;
    w_ram_oce = 1'b0;
    w_ram_wre = 1'b0;
    w_ram_ad  = r_ram_ad;
    w_ram_din = r_ram_din;

    // Inter-byte idle watchdog; an accepted byte always restarts it.
    if (w_in_frame) begin
      if (w_accept) begin
        w_tcnt = '0;
      end else if (r_tcnt == TMO_W'(TIMEOUT_CYC - 1)) begin
        w_state = S_ERROR;
        w_err   = 3'd3;
      end else begin
        w_tcnt = r_tcnt + 1'b1;
      end
    end

    case (r_state)
      S_IDLE, S_ERROR: begin
        if (w_accept && (bus.s_data == SYNC_BYTE)) begin
          w_state = S_LEN_H;
          w_err   = 3'd0;
          w_sum   = 8'd0;
          w_tcnt  = '0;
        end
      end
      S_LEN_H: begin
        if (w_accept) begin
          w_len_hi = bus.s_data;
          w_state  = S_LEN_L;
        end
      end
      S_LEN_L: begin
        if (w_accept) begin
          if ((w_len16 != 16'd0) && ({1'b0, w_len16} <= MAX_LEN)) begin
            w_len   = CNT_W'(w_len16);
            w_cnt   = '0;
            w_state = S_DATA;
          end else begin
            w_state = S_ERROR;
            w_err   = 3'd1;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_ram_ce  = 1'b1;
          w_ram_wre = 1'b1;
          w_ram_ad  = r_cnt[ADDR_W-1:0];
          w_ram_din = bus.s_data;
          w_sum     = r_sum + bus.s_data;
          w_cnt     = w_cnt_inc;
          if (r_cnt == r_len - 1'b1) begin
            w_state = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (w_accept) begin
          w_chk = bus.s_data;
          if (8'(r_sum + bus.s_data) != 8'd0) begin
            w_state = S_ERROR;
            w_err   = 3'd2;
          end else begin
            // First read (address 0) is issued in the VERIFY entry cycle.
            w_state   = S_VERIFY;
            w_cnt     = '0;
            w_rsum    = 8'd0;
            w_ram_ce  = 1'b1;
            w_ram_oce = 1'b1;
            w_ram_ad  = '0;
          end
        end
      end
      S_VERIFY: begin
        // r_cnt counts verify cycles; data for address c-1 arrives in cycle c.
        if (r_cnt != '0) begin
          w_rsum = r_rsum + bus.ram_dout;
        end
        if (r_cnt == r_len) begin
          if (w_vsum == 8'd0) begin
            w_state = S_DONE;
          end else begin
            w_state = S_ERROR;
            w_err   = 3'd4;
          end
        end else begin
          w_cnt = w_cnt_inc;
          if (w_cnt_inc < r_len) begin
            w_ram_ce  = 1'b1;
            w_ram_oce = 1'b1;
            w_ram_ad  = w_cnt_inc[ADDR_W-1:0];
          end
        end
      end
      S_DONE: begin
        // Terminal until reset; bytes are accepted and dropped.
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Datapath registers and registered RAM-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err     <= 3'd0;
      r_len_hi  <= 8'd0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_sum     <= 8'd0;
      r_rsum    <= 8'd0;
      r_chk     <= 8'd0;
      r_tcnt    <= '0;
      r_ram_ce  <= 1'b0;
      r_ram_oce <= 1'b0;
      r_ram_wre <= 1'b0;
      r_ram_ad  <= '0;
      r_ram_din <= 8'd0;
    end else begin
      r_err     <= w_err;
      r_len_hi  <= w_len_hi;
      r_len     <= w_len;
      r_cnt     <= w_cnt;
      r_sum     <= w_sum;
      r_rsum    <= w_rsum;
      r_chk     <= w_chk;
      r_tcnt    <= w_tcnt;
      r_ram_ce  <= w_ram_ce;
      r_ram_oce <= w_ram_oce;
      r_ram_wre <= w_ram_wre;
      r_ram_ad  <= w_ram_ad;
      r_ram_din <= w_ram_din;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.ram_ce  = r_ram_ce;
  assign bus.ram_oce = r_ram_oce;
  assign bus.ram_wre = r_ram_wre;
  assign bus.ram_ad  = r_ram_ad;
  assign bus.ram_din = r_ram_din;
  assign done        = (r_state == S_DONE);
  assign cpu_hold    = (r_state != S_DONE);
  assign err         = r_err;

endmodule

// File: tb/tb_boot_image_loader.sv
// Bench for boot_image_loader: directed frames, a frame-level reference
// model checked every cycle, and hand-computed literal checks.
module tb_boot_image_loader;
  localparam int AW  = 11;
  localparam int TMO = 40;
  localparam int CAP = 1 << AW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_hold, done;
  logic [2:0] err;
  logic [7:0] ram_q = 8'd0;
  logic [7:0] mem [0:CAP-1];
  bit         corrupt = 1'b0;
  logic [7:0] pay [0:CAP-1];

  int total = 0;
  int bad   = 0;

  boot_image_loader_if #(.ADDR_W(AW)) bus ();

  boot_image_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Boot RAM: registered read, write data bypassed to the output; address 2
  // optionally reads back with bit 0 flipped.
  assign bus.ram_dout = ram_q;
  always @(posedge clk) begin
    if (bus.ram_ce && bus.ram_wre) begin
      mem[bus.ram_ad] <= bus.ram_din;
      ram_q <= bus.ram_din;
    end else if (bus.ram_ce) begin
      ram_q <= mem[bus.ram_ad] ^ ((corrupt && bus.ram_ad == 2) ? 8'h01 : 8'h00);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit         m_live = 0;
  bit         m_inframe = 0;
  bit         m_done = 0;
  int         m_err = 0;
  int         m_pos = 0;
  int         m_len = 0;
  int         m_sum = 0;
  int         m_idle = 0;
  int         m_vleft = 0;
  bit         m_vok = 0;
  bit         m_wr = 0;
  int         m_wa = 0;
  int         m_wd = 0;
  logic [7:0] m_pay [0:CAP-1];

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_live = 1; m_inframe = 0; m_done = 0; m_err = 0; m_pos = 0;
        m_idle = 0; m_vleft = 0; m_wr = 0;
      end else begin
        bit acc;
        acc  = bus.s_valid && (m_vleft == 0);
        m_wr = 0;
        if (m_vleft > 0) begin
          m_vleft--;
          if (m_vleft == 0) begin
            if (m_vok) m_done = 1;
            else m_err = 4;
          end
        end else if (m_done) begin
          // bytes dropped once loaded
        end else if (!m_inframe) begin
          if (acc && bus.s_data == 8'hA5) begin
            m_inframe = 1; m_pos = 0; m_err = 0; m_idle = 0; m_sum = 0;
          end
        end else if (!acc) begin
          m_idle++;
          if (m_idle == TMO) begin
            m_inframe = 0; m_err = 3;
          end
        end else begin
          m_idle = 0;
          if (m_pos == 0) begin
            m_len = int'(bus.s_data) * 256;
          end else if (m_pos == 1) begin
            m_len = m_len + int'(bus.s_data);
            if (m_len < 1 || m_len > CAP) begin
              m_inframe = 0; m_err = 1;
            end
          end else if (m_pos - 2 < m_len) begin
            m_pay[m_pos-2] = bus.s_data;
            m_sum = m_sum + int'(bus.s_data);
            m_wr = 1; m_wa = m_pos - 2; m_wd = int'(bus.s_data);
          end else begin
            int rb;
            m_inframe = 0;
            if (((m_sum + int'(bus.s_data)) % 256) != 0) begin
              m_err = 2;
            end else begin
              rb = int'(bus.s_data);
              for (int k = 0; k < m_len; k++)
                rb = rb + int'(m_pay[k] ^ ((corrupt && k == 2) ? 8'h01 : 8'h00));
              m_vok   = (rb % 256) == 0;
              m_vleft = m_len + 1;
            end
          end
          m_pos++;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      bit rd;
      rd = (m_vleft >= 2);
      check("s_ready", 32'(bus.s_ready), 32'(m_vleft == 0));
      check("done", 32'(done), 32'(m_done));
      check("cpu_hold", 32'(cpu_hold), 32'(!m_done));
      check("err", 32'(err), 32'(m_err));
      check("ram_ce", 32'(bus.ram_ce), 32'(m_wr || rd));
      check("ram_wre", 32'(bus.ram_wre), 32'(m_wr));
      check("ram_oce", 32'(bus.ram_oce), 32'(rd));
      if (m_wr) begin
        check("wr_addr", 32'(bus.ram_ad), 32'(m_wa));
        check("wr_data", 32'(bus.ram_din), 32'(m_wd));
      end else if (rd) begin
        check("rd_addr", 32'(bus.ram_ad), 32'(m_len + 1 - m_vleft));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic frame4(input logic [7:0] c);
    put(8'hA5); put(8'h00); put(8'h04);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    put(c);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    check({tag, "_ram_ce"}, 32'(bus.ram_ce), 32'd0);
    check({tag, "_ram_oce"}, 32'(bus.ram_oce), 32'd0);
    check({tag, "_ram_wre"}, 32'(bus.ram_wre), 32'd0);
    check({tag, "_ram_ad"}, 32'(bus.ram_ad), 32'd0);
    check({tag, "_ram_din"}, 32'(bus.ram_din), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    logic [7:0] c;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Leading garbage, then a good 4-byte frame.
    put(8'h00); put(8'hFF);
    frame4(8'h56);
    gap(5);
    check("A_done_early", 32'(done), 32'd0);
    gap(1);
    check("A_done", 32'(done), 32'd1);
    check("A_cpu_hold", 32'(cpu_hold), 32'd0);
    check("A_err", 32'(err), 32'd0);
    check("A_mem0", 32'(mem[0]), 32'h11);
    check("A_mem3", 32'(mem[3]), 32'h44);
    put(8'hA5); gap(2);
    check("A_done_hold", 32'(done), 32'd1);

    // Bad receive checksum, then recovery with a correct frame.
    do_reset();
    frame4(8'h57);
    gap(1);
    check("B_err", 32'(err), 32'd2);
    check("B_cpu_hold", 32'(cpu_hold), 32'd1);
    frame4(8'h56);
    gap(6);
    check("B_done", 32'(done), 32'd1);
    check("B_err_clr", 32'(err), 32'd0);

    // Bad lengths: 0 and 2049.
    do_reset();
    put(8'hA5); put(8'h00); put(8'h00);
    gap(1);
    check("L0_err", 32'(err), 32'd1);
    check("L0_ce", 32'(bus.ram_ce), 32'd0);
    put(8'hA5); put(8'h08); put(8'h01);
    gap(1);
    check("L2049_err", 32'(err), 32'd1);
    check("L2049_ce", 32'(bus.ram_ce), 32'd0);

    // Timeout after two payload bytes.
    do_reset();
    put(8'hA5); put(8'h00); put(8'h04); put(8'h11); put(8'h22);
    gap(TMO);
    check("T_err_before", 32'(err), 32'd0);
    check("T_ready_before", 32'(bus.s_ready), 32'd1);
    gap(1);
    check("T_err", 32'(err), 32'd3);
    check("T_ready", 32'(bus.s_ready), 32'd1);

    // Readback corruption at address 2.
    do_reset();
    corrupt = 1'b1;
    frame4(8'h56);
    gap(6);
    check("V_err", 32'(err), 32'd4);
    check("V_done", 32'(done), 32'd0);
    check("V_cpu_hold", 32'(cpu_hold), 32'd1);
    corrupt = 1'b0;

    // Reset during DATA after two bytes.
    do_reset();
    put(8'hA5); put(8'h00); put(8'h04); put(8'h11); put(8'h22);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    rst_n = 1'b1;

    // Full-capacity frame.
    s = 0;
    for (int k = 0; k < CAP; k++) begin
      pay[k] = 8'((k * 7 + 3) % 256);
      s = s + int'(pay[k]);
    end
    c = 8'((256 - (s % 256)) % 256);
    put(8'hA5); put(8'h08); put(8'h00);
    for (int k = 0; k < CAP; k++) put(pay[k]);
    gap(1);
    check("F_last_ad", 32'(bus.ram_ad), 32'h7FF);
    check("F_last_wre", 32'(bus.ram_wre), 32'd1);
    check("F_last_din", 32'(bus.ram_din), 32'(pay[CAP-1]));
    put(c);
    gap(CAP + 1);
    check("F_done_early", 32'(done), 32'd0);
    gap(1);
    check("F_done", 32'(done), 32'd1);
    check("F_err", 32'(err), 32'd0);
    check("F_mem7ff", 32'(mem[CAP-1]), 32'(pay[CAP-1]));
    gap(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
